// File: rtl/alu_seq_core.sv
// Registered, handshaked ALU keeping the original 3-bit opcode map and dir/bite semantics.
// Shifts/rotates either complete in one cycle or advance one bit per cycle under an FSM.
module alu_seq_core #(
    parameter int WIDTH        = 32,
    parameter int SHW          = $clog2(WIDTH),
    parameter int SERIAL_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CI,
    input  logic [2:0]       F,
    input  logic [1:0]       dir,
    input  logic [SHW-1:0]   bite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned MAXN = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [SHW-1:0]   count;
    logic [1:0]       sdir;

    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] sh_v;
    logic             sh_co;
    logic             res_co;
    logic             res_ovf;
    logic             serial_go;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   nxt;

    // One-bit move; returns {bit that left its position across the boundary, new word}.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] v, input logic [1:0] d);
        case (d)
            2'b00:   step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            2'b01:   step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            2'b10:   step = {v[0], 1'b0, v[WIDTH-1:1]};
            default: step = {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        ones  = '1;
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, CI};
        sh_v  = a;
        sh_co = 1'b0;
        // Same single-bit step as the serial path, so both modes give identical results.
        for (int unsigned i = 0; i < MAXN; i++) begin
            if (i < 32'(bite)) {sh_co, sh_v} = step(sh_v, dir);
        end

        res_s   = '0;
        res_co  = 1'b0;
        res_ovf = 1'b0;
        case (F)
            3'b000: res_s = '0;
            3'b001: begin
                {res_co, res_s} = sum;
                res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: begin
                res_s  = sh_v;
                res_co = sh_co;
            end
            3'b011: res_s = dir[1] ? (a & (ones << bite)) : (a & (ones >> bite));
            3'b100: res_s = a & b;
            3'b101: res_s = a | b;
            3'b110: res_s = ~a;
            default: res_s = a ^ b;
        endcase

        serial_go = (SERIAL_SHIFT != 0) && (F == 3'b010) && (bite != '0);
        nxt       = step(S, sdir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            S     <= '0;
            CO    <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
            sdir  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (serial_go) begin
                        S     <= a;
                        CO    <= 1'b0;
                        zero  <= 1'b0;
                        ovf   <= 1'b0;
                        count <= bite;
                        sdir  <= dir;
                        state <= SHIFT;
                    end else begin
                        S     <= res_s;
                        CO    <= res_co;
                        zero  <= (res_s == '0);
                        ovf   <= res_ovf;
                        state <= DONE;
                    end
                end
                SHIFT: begin
                    {CO, S} <= nxt;
                    count   <= count - 1'b1;
                    if (count == SHW'(1)) begin
                        zero  <= (nxt[WIDTH-1:0] == '0);
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_seq_core.sv
// Drives a serial-shift and a single-cycle-shift instance with identical operations
// and compares both against an arithmetic reference model.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        ci;
    logic [2:0]  f;
    logic [1:0]  dir;
    logic [4:0]  bite;
    logic        out_ready;

    logic        in_ready_s, out_valid_s, co_s, zero_s, ovf_s;
    logic [31:0] s_s;
    logic        in_ready_p, out_valid_p, co_p, zero_p, ovf_p;
    logic [31:0] s_p;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(32), .SERIAL_SHIFT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .CI(ci), .F(f), .dir(dir), .bite(bite),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .S(s_s), .CO(co_s), .zero(zero_s), .ovf(ovf_s)
    );

    alu_seq_core #(.WIDTH(32), .SERIAL_SHIFT(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p),
        .a(a), .b(b), .CI(ci), .F(f), .dir(dir), .bite(bite),
        .out_valid(out_valid_p), .out_ready(out_ready),
        .S(s_p), .CO(co_p), .zero(zero_p), .ovf(ovf_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, zero, CO, S}.
    function automatic logic [34:0] model(input logic [2:0] fo, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic [1:0] d, input logic [4:0] n);
        logic [31:0] r;
        logic        co, ov;
        logic [63:0] t;
        logic [32:0] sm;
        logic [5:0]  inv;
        r = 32'h0; co = 1'b0; ov = 1'b0;
        inv = 6'd32 - {1'b0, n};
        case (fo)
            3'd0: r = 32'h0;
            3'd1: begin
                sm = {1'b0, x} + {1'b0, y} + {32'h0, c};
                r  = sm[31:0];
                co = sm[32];
                ov = (x[31] == y[31]) && (r[31] != x[31]);
            end
            3'd2: begin
                if (n == 5'd0) r = x;
                else case (d)
                    2'b00: begin t = {32'h0, x} << n; r = t[31:0];  co = t[32]; end
                    2'b10: begin t = {x, 32'h0} >> n; r = t[63:32]; co = t[31]; end
                    2'b01: begin r = (x << n) | (x >> inv); co = r[0];  end
                    default: begin r = (x >> n) | (x << inv); co = r[31]; end
                endcase
            end
            3'd3: r = d[1] ? ((x >> n) << n) : ((x << n) >> n);
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = ~x;
            default: r = x ^ y;
        endcase
        return {ov, (r == 32'h0), co, r};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] fi, input logic [31:0] ai, input logic [31:0] bi,
                          input logic cii, input logic [1:0] di, input logic [4:0] ni,
                          input bit use_c, input logic [31:0] cs, input logic cco, input int hold);
        logic [34:0] m;
        int edges, lat_s, lat_p, exp_lat;
        bit seen_s, seen_p;
        m = model(fi, ai, bi, cii, di, ni);
        exp_lat = (fi == 3'd2 && ni != 5'd0) ? int'(ni) : 0;
        seen_s = 0; seen_p = 0; lat_s = -1; lat_p = -1;

        @(negedge clk);
        check({tag, ":in_ready_s"}, in_ready_s, 1);
        check({tag, ":in_ready_p"}, in_ready_p, 1);
        f = fi; a = ai; b = bi; ci = cii; dir = di; bite = ni;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; f = 3'($urandom); dir = 2'($urandom); bite = 5'($urandom); ci = 1'($urandom);

        edges = 0;
        while (1) begin
            @(negedge clk);
            if (!seen_s && out_valid_s) begin seen_s = 1; lat_s = edges; end
            else if (!seen_s) check({tag, ":busy_in_ready_s"}, in_ready_s, 0);
            if (!seen_p && out_valid_p) begin seen_p = 1; lat_p = edges; end
            if ((seen_s && seen_p) || edges >= 100) break;
            @(posedge clk);
            edges++;
        end

        check({tag, ":completed"}, {31'h0, seen_s && seen_p}, 1);
        check({tag, ":latency_s"}, lat_s, exp_lat);
        check({tag, ":latency_p"}, lat_p, 0);
        check({tag, ":S_s"},    s_s,    m[31:0]);
        check({tag, ":CO_s"},   co_s,   m[32]);
        check({tag, ":zero_s"}, zero_s, m[33]);
        check({tag, ":ovf_s"},  ovf_s,  m[34]);
        check({tag, ":S_p"},    s_p,    m[31:0]);
        check({tag, ":CO_p"},   co_p,   m[32]);
        check({tag, ":zero_p"}, zero_p, m[33]);
        check({tag, ":ovf_p"},  ovf_p,  m[34]);
        if (use_c) begin
            check({tag, ":S_const"},  s_s,  cs);
            check({tag, ":CO_const"}, co_s, cco);
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ":hold_valid"},    out_valid_s, 1);
            check({tag, ":hold_in_ready"}, in_ready_s,  0);
            check({tag, ":hold_S"},        s_s,  m[31:0]);
            check({tag, ":hold_CO"},       co_s, m[32]);
            check({tag, ":hold_zero"},     zero_s, m[33]);
            check({tag, ":hold_ovf"},      ovf_s,  m[34]);
            check({tag, ":hold_S_p"},      s_p,  m[31:0]);
            if (i == 1) begin
                in_valid = 1'b1; f = 3'd1; a = 32'h1234_5678; b = 32'h1111_1111;
            end else begin
                in_valid = 1'b0;
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":released_in_ready_s"},  in_ready_s,  1);
        check({tag, ":released_in_ready_p"},  in_ready_p,  1);
        check({tag, ":released_out_valid_s"}, out_valid_s, 0);
        check({tag, ":released_out_valid_p"}, out_valid_p, 0);
        check({tag, ":released_S_s"},         s_s, m[31:0]);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [4:0]  rn;
        logic [1:0]  rd;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; f = '0; dir = '0; bite = '0;
        repeat (2) @(negedge clk);
        check("reset:S",         s_s, 0);
        check("reset:CO",        co_s, 0);
        check("reset:zero",      zero_s, 0);
        check("reset:ovf",       ovf_s, 0);
        check("reset:out_valid", out_valid_s, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset:in_ready", in_ready_s, 1);

        run_op("add_small", 3'd1, 32'h7F,         32'h1F, 1'b0, 2'b00, 5'd0,  1, 32'h9E,        1'b0, 0);
        run_op("add_wrap",  3'd1, 32'hFFFF_FFFF,  32'h1,  1'b0, 2'b00, 5'd0,  1, 32'h0,         1'b1, 0);
        run_op("add_ovf",   3'd1, 32'h7FFF_FFFF,  32'h1,  1'b0, 2'b00, 5'd0,  1, 32'h8000_0000, 1'b0, 0);
        run_op("add_ci",    3'd1, 32'h10,         32'h20, 1'b1, 2'b00, 5'd0,  1, 32'h31,        1'b0, 0);
        run_op("shl7",      3'd2, 32'h01FF_FFFF,  32'h0,  1'b0, 2'b00, 5'd7,  1, 32'hFFFF_FF80, 1'b0, 0);
        run_op("rotr7",     3'd2, 32'h0003_FFFF,  32'h0,  1'b0, 2'b11, 5'd7,  1, 32'hFE00_07FF, 1'b1, 0);
        run_op("rotl4",     3'd2, 32'hF000_0001,  32'h0,  1'b0, 2'b01, 5'd4,  1, 32'h0000_001F, 1'b1, 0);
        run_op("shr31",     3'd2, 32'hC000_0000,  32'h0,  1'b0, 2'b10, 5'd31, 1, 32'h1,         1'b1, 0);
        run_op("shift0",    3'd2, 32'hDEAD_BEEF,  32'h0,  1'b0, 2'b01, 5'd0,  1, 32'hDEAD_BEEF, 1'b0, 0);
        run_op("trunc_lo",  3'd3, 32'h3FFF_FFFF,  32'h0,  1'b0, 2'b00, 5'd30, 1, 32'h3,         1'b0, 0);
        run_op("trunc_hi",  3'd3, 32'h7FFF_FFFF,  32'h0,  1'b0, 2'b10, 5'd30, 1, 32'h4000_0000, 1'b0, 0);
        run_op("zero_op",   3'd0, 32'h1234_5678,  32'h9,  1'b1, 2'b00, 5'd3,  1, 32'h0,         1'b0, 0);
        run_op("and",       3'd4, 32'h7F,         32'h70, 1'b0, 2'b00, 5'd0,  1, 32'h70,        1'b0, 0);
        run_op("or",        3'd5, 32'h76,         32'h30, 1'b0, 2'b00, 5'd0,  1, 32'h76,        1'b0, 0);
        run_op("not",       3'd6, 32'h7F,         32'h0,  1'b0, 2'b00, 5'd0,  1, 32'hFFFF_FF80, 1'b0, 0);
        run_op("xor_bp",    3'd7, 32'hFF,         32'h47, 1'b0, 2'b00, 5'd0,  1, 32'hB8,        1'b0, 5);

        // Reset three cycles into a 20-bit serial shift.
        @(negedge clk);
        f = 3'd2; a = 32'hA5A5_0F0F; dir = 2'b00; bite = 5'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst:out_valid_s", out_valid_s, 0);
        check("midrst:S_s",         s_s, 0);
        check("midrst:CO_s",        co_s, 0);
        check("midrst:out_valid_p", out_valid_p, 0);
        check("midrst:S_p",         s_p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst:in_ready_s", in_ready_s, 1);
        repeat (25) @(negedge clk);
        check("midrst:no_partial", out_valid_s, 0);
        run_op("add_after_rst", 3'd1, 32'h0000_0100, 32'h0000_00FF, 1'b1, 2'b00, 5'd0, 1, 32'h200, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            rf = 3'($urandom_range(0, 7));
            if (k % 3 == 0) rf = 3'd2;
            rn = 5'($urandom_range(0, 31));
            rd = 2'($urandom);
            run_op("rand", rf, $urandom, $urandom, 1'($urandom), rd, rn, 0, 32'h0, 1'b0,
                   ($urandom_range(0, 3) == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
